// File: rtl/ram_sym_unpack.sv
// Reads a frame of RAM words and unpacks each into fixed-width symbols, LSB first,
// streamed on a valid/ready interface with first/last markers.
module ram_sym_unpack #(
    parameter int RAM_W   = 32,
    parameter int ADDR_W  = 10,
    parameter int SYM_W_A = 6,
    parameter int SPW_A   = 5,
    parameter int SYM_W_B = 4,
    parameter int SPW_B   = 8,
    localparam int SYM_W  = (SYM_W_A > SYM_W_B) ? SYM_W_A : SYM_W_B
) (
    input  logic              clk_15_o,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_cnt,
    input  logic              abort,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [RAM_W-1:0]  ram_dout,
    output logic [SYM_W-1:0]  sym,
    output logic              sym_valid,
    input  logic              sym_ready,
    output logic              sym_first,
    output logic              sym_last,
    output logic              busy,
    output logic              done
);

    localparam int SPW_MAX = (SPW_A > SPW_B) ? SPW_A : SPW_B;
    localparam int IDX_W   = (SPW_MAX > 1) ? $clog2(SPW_MAX) : 1;

    if (SPW_A * SYM_W_A > RAM_W || SPW_B * SYM_W_B > RAM_W) begin : g_pack_check
        $error("ram_sym_unpack: symbols per word exceed RAM_W");
    end

    typedef enum logic [1:0] {IDLE, FETCH, RUN, FLUSH} state_t;

    state_t             state, state_nxt;
    logic               mode_r;
    logic [ADDR_W-1:0]  cnt_r;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ADDR_W-1:0]  rd_cnt;
    logic [ADDR_W-1:0]  wd_idx;
    logic [IDX_W-1:0]   sym_idx;
    logic [IDX_W-1:0]   last_idx;
    logic               vld_p1;
    logic               zdone;
    logic [RAM_W-1:0]   cur_word, pf_word;
    logic               cur_valid, pf_valid;
    logic               cur_valid_nxt, pf_valid_nxt;
    logic               cur_free, cur_load, pf_load;
    logic               accept, launch, kill, xfer, word_end, issue;
    logic [2:0]         slots;

    function automatic logic [SYM_W-1:0] extract(input logic [RAM_W-1:0] w,
                                                 input logic [IDX_W-1:0] idx,
                                                 input logic m);
        logic [RAM_W-1:0] sh;
        logic [SYM_W-1:0] mask;
        if (m) begin
            sh   = w >> (32'(idx) * SYM_W_B);
            mask = SYM_W'((1 << SYM_W_B) - 1);
        end else begin
            sh   = w >> (32'(idx) * SYM_W_A);
            mask = SYM_W'((1 << SYM_W_A) - 1);
        end
        return sh[SYM_W-1:0] & mask;
    endfunction

    assign busy      = (state != IDLE);
    assign accept    = start && !abort && (state == IDLE);
    assign launch    = accept && (word_cnt != '0);
    assign kill      = abort && busy;
    assign last_idx  = mode_r ? IDX_W'(SPW_B - 1) : IDX_W'(SPW_A - 1);
    assign sym_valid = (state == RUN) && cur_valid;
    assign xfer      = sym_valid && sym_ready;
    assign word_end  = (sym_idx == last_idx);
    assign sym_first = sym_valid && (sym_idx == '0) && (wd_idx == '0);
    assign sym_last  = sym_valid && word_end && (wd_idx == cnt_r - ADDR_W'(1));
    assign sym       = sym_valid ? extract(cur_word, sym_idx, mode_r) : '0;
    assign done      = (state == FLUSH) || zdone;

    // One read in flight at most per free slot: current word, prefetch word, or data returning.
    assign slots = 3'(cur_valid) + 3'(pf_valid) + 3'(vld_p1) + 3'(ram_rd);
    assign issue = ((state == FETCH) || (state == RUN)) && (rd_cnt != cnt_r) && (slots < 3'd2);

    always_comb begin
        cur_free      = !cur_valid || (xfer && word_end);
        cur_load      = cur_free && (pf_valid || vld_p1);
        pf_load       = vld_p1 && !(cur_free && !pf_valid);
        cur_valid_nxt = cur_free ? (pf_valid || vld_p1) : 1'b1;
        pf_valid_nxt  = pf_load ? 1'b1 : (cur_free ? 1'b0 : pf_valid);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (launch) state_nxt = FETCH;
            FETCH:   if (vld_p1) state_nxt = RUN;
            RUN:     if (xfer && sym_last) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk_15_o) begin
        if (rst) begin
            state     <= IDLE;
            mode_r    <= 1'b0;
            cnt_r     <= '0;
            rd_addr   <= '0;
            rd_cnt    <= '0;
            wd_idx    <= '0;
            sym_idx   <= '0;
            ram_rd    <= 1'b0;
            ram_addr  <= '0;
            vld_p1    <= 1'b0;
            zdone     <= 1'b0;
            cur_valid <= 1'b0;
            pf_valid  <= 1'b0;
        end else begin
            state  <= state_nxt;
            zdone  <= accept && (word_cnt == '0);
            vld_p1 <= ram_rd && !kill;
            if (kill) begin
                ram_rd    <= 1'b0;
                ram_addr  <= '0;
                cur_valid <= 1'b0;
                pf_valid  <= 1'b0;
            end else if (launch) begin
                mode_r    <= mode;
                cnt_r     <= word_cnt;
                ram_rd    <= 1'b1;
                ram_addr  <= base_addr;
                rd_addr   <= base_addr + ADDR_W'(1);
                rd_cnt    <= ADDR_W'(1);
                wd_idx    <= '0;
                sym_idx   <= '0;
                cur_valid <= 1'b0;
                pf_valid  <= 1'b0;
            end else begin
                ram_rd    <= issue;
                cur_valid <= cur_valid_nxt;
                pf_valid  <= pf_valid_nxt;
                if (issue) begin
                    ram_addr <= rd_addr;
                    rd_addr  <= rd_addr + ADDR_W'(1);
                    rd_cnt   <= rd_cnt + ADDR_W'(1);
                end
                if (xfer) begin
                    if (word_end) begin
                        sym_idx <= '0;
                        wd_idx  <= wd_idx + ADDR_W'(1);
                    end else begin
                        sym_idx <= sym_idx + IDX_W'(1);
                    end
                end
            end
        end
    end

    // Word registers carry data only; their valid flags live in the control block above.
    always_ff @(posedge clk_15_o) begin
        if (cur_load) cur_word <= pf_valid ? pf_word : ram_dout;
        if (pf_load)  pf_word  <= ram_dout;
    end

endmodule

// File: tb/tb_ram_sym_unpack.sv
// Directed bench for ram_sym_unpack: table of frames plus hand-written abort,
// reset, zero-length and start-collision sequences.
module tb_ram_sym_unpack;

    logic        clk_15_o = 1'b0;
    logic        rst, start, mode, abort, sym_ready;
    logic [9:0]  base_addr, word_cnt, ram_addr;
    logic        ram_rd, sym_valid, sym_first, sym_last, busy, done;
    logic [31:0] ram_dout;
    logic [5:0]  sym;
    logic [31:0] ram [1024];

    always #5 clk_15_o = ~clk_15_o;

    always @(posedge clk_15_o) ram_dout <= ram_rd ? ram[ram_addr] : 32'hDEAD_BEEF;

    ram_sym_unpack dut (
        .clk_15_o  (clk_15_o),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .abort     (abort),
        .ram_rd    (ram_rd),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .sym       (sym),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_first (sym_first),
        .sym_last  (sym_last),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic        mode;
        logic [9:0]  base;
        logic [9:0]  cnt;
        logic [31:0] w0, w1, w2;
        logic        toggle;
        logic        flush_start;
        int          off;
        int          n;
        logic [9:0]  a1;
    } vec_t;

    vec_t vecs[5];
    int   exp_stream[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_15_o);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_rd"}, ram_rd, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_sym"}, sym, 0);
        chk({tag, "_sym_valid"}, sym_valid, 0);
        chk({tag, "_sym_first"}, sym_first, 0);
        chk({tag, "_sym_last"}, sym_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic run_frame(input int vi);
        vec_t       v;
        int         k, rd_n, last_cyc, flush_cyc;
        logic       done_seen, prev_stall, prev_first, prev_last;
        logic [5:0] prev_sym;
        logic [9:0] a;
        v = vecs[vi];
        a = v.base;          ram[a] = v.w0;
        a = a + 10'd1;       ram[a] = v.w1;
        a = a + 10'd1;       ram[a] = v.w2;
        tick();
        start = 1'b1; mode = v.mode; base_addr = v.base; word_cnt = v.cnt; sym_ready = 1'b1;
        k = 0; rd_n = 0; last_cyc = -10; flush_cyc = -10;
        done_seen = 1'b0; prev_stall = 1'b0; prev_first = 1'b0; prev_last = 1'b0; prev_sym = '0;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            tick();
            start = 1'b0; mode = ~v.mode; base_addr = ~v.base; word_cnt = 10'd7;
            if (cyc == flush_cyc + 1) begin
                chk($sformatf("v%0d_flush_start_busy", vi), busy, 0);
                chk($sformatf("v%0d_flush_start_rd", vi), ram_rd, 0);
                break;
            end
            sym_ready = v.toggle ? cyc[0] : 1'b1;
            if (cyc == 1) begin
                chk($sformatf("v%0d_first_rd", vi), ram_rd, 1);
                chk($sformatf("v%0d_first_addr", vi), ram_addr, v.base);
            end
            if (cyc == 2) chk($sformatf("v%0d_valid_c2", vi), sym_valid, 0);
            if (cyc == 3) chk($sformatf("v%0d_valid_c3", vi), sym_valid, 1);
            if (ram_rd) begin
                rd_n++;
                if (rd_n == 2) chk($sformatf("v%0d_second_addr", vi), ram_addr, v.a1);
            end
            if (sym_valid) begin
                if (prev_stall) begin
                    chk($sformatf("v%0d_stall_sym", vi), sym, prev_sym);
                    chk($sformatf("v%0d_stall_first", vi), sym_first, prev_first);
                    chk($sformatf("v%0d_stall_last", vi), sym_last, prev_last);
                end
                if (k < v.n) begin
                    chk($sformatf("v%0d_sym%0d", vi, k), sym, exp_stream[v.off + k]);
                    chk($sformatf("v%0d_first%0d", vi, k), sym_first, k == 0);
                    chk($sformatf("v%0d_last%0d", vi, k), sym_last, k == v.n - 1);
                end else begin
                    chk($sformatf("v%0d_extra_sym", vi), k, v.n - 1);
                end
                prev_sym = sym; prev_first = sym_first; prev_last = sym_last;
                prev_stall = !sym_ready;
                if (sym_ready) begin
                    k++;
                    if (k == v.n) last_cyc = cyc;
                end
            end else begin
                prev_stall = 1'b0;
                if (!v.toggle && k > 0 && k < v.n) chk($sformatf("v%0d_no_gap%0d", vi, k), sym_valid, 1);
            end
            if (done) begin
                done_seen = 1'b1;
                chk($sformatf("v%0d_done_timing", vi), cyc, last_cyc + 1);
                if (v.flush_start) begin
                    start = 1'b1; word_cnt = 10'd1; flush_cyc = cyc;
                end else begin
                    break;
                end
            end
        end
        start = 1'b0;
        chk($sformatf("v%0d_done_seen", vi), done_seen, 1);
        chk($sformatf("v%0d_sym_count", vi), k, v.n);
        chk($sformatf("v%0d_rd_count", vi), rd_n, v.cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, bad;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
        base_addr = '0; word_cnt = '0; sym_ready = 1'b0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;

        vecs[0] = '{mode: 1'b1, base: 10'h010, cnt: 10'd1, w0: 32'h12345678, w1: 32'h0, w2: 32'h0,
                    toggle: 1'b0, flush_start: 1'b1, off: 0, n: 8, a1: 10'h0};
        vecs[1] = '{mode: 1'b0, base: 10'h040, cnt: 10'd2, w0: 32'h00000041, w1: 32'hC0000FC0, w2: 32'h0,
                    toggle: 1'b0, flush_start: 1'b0, off: 8, n: 10, a1: 10'h041};
        vecs[2] = '{mode: 1'b1, base: 10'h080, cnt: 10'd3, w0: 32'h76543210, w1: 32'hFEDCBA98, w2: 32'h0F1E2D3C,
                    toggle: 1'b1, flush_start: 1'b0, off: 18, n: 24, a1: 10'h081};
        vecs[3] = '{mode: 1'b1, base: 10'h3FF, cnt: 10'd2, w0: 32'hAAAA5555, w1: 32'h13579BDF, w2: 32'h0,
                    toggle: 1'b0, flush_start: 1'b0, off: 42, n: 16, a1: 10'h000};
        vecs[4] = '{mode: 1'b0, base: 10'h200, cnt: 10'd1, w0: 32'h05103081, w1: 32'h0, w2: 32'h0,
                    toggle: 1'b0, flush_start: 1'b0, off: 58, n: 5, a1: 10'h0};
        exp_stream = '{8, 7, 6, 5, 4, 3, 2, 1,
                       1, 1, 0, 0, 0, 0, 63, 0, 0, 0,
                       0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 12, 3, 13, 2, 14, 1, 15, 0,
                       5, 5, 5, 5, 10, 10, 10, 10, 15, 13, 11, 9, 7, 5, 3, 1,
                       1, 2, 3, 4, 5};

        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        for (int vi = 0; vi < 4; vi++) run_frame(vi);

        // zero-length frame
        tick();
        start = 1'b1; mode = 1'b0; base_addr = 10'h005; word_cnt = 10'd0;
        tick();
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_rd", ram_rd, 0);
        tick();
        chk("zero_done_once", done, 0);
        chk("zero_rd_after", ram_rd, 0);

        // abort after the third symbol of a 4-word mode A frame
        ram[10'h100] = 32'h05103081;
        ram[10'h101] = 32'hFFFFFFFF;
        ram[10'h102] = 32'h0A0A0A0A;
        ram[10'h103] = 32'h12121212;
        tick();
        start = 1'b1; mode = 1'b0; base_addr = 10'h100; word_cnt = 10'd4; sym_ready = 1'b1;
        k = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            start = 1'b0;
            if (k == 3) begin
                abort = 1'b1; sym_ready = 1'b0;
                break;
            end
            if (sym_valid) begin
                chk($sformatf("abort_pre_sym%0d", k), sym, k + 1);
                k++;
            end
        end
        chk("abort_pre_count", k, 3);
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", sym_valid, 0);
        chk("abort_rd", ram_rd, 0);
        chk("abort_done", done, 0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || ram_rd || busy || sym_valid) bad = 1;
        end
        chk("abort_quiet", bad, 0);

        run_frame(4);

        // abort and start together: start dropped
        tick();
        start = 1'b1; abort = 1'b1; mode = 1'b1; base_addr = 10'h010; word_cnt = 10'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abst_busy", busy, 0);
        chk("abst_rd", ram_rd, 0);
        tick();
        chk("abst_valid", sym_valid, 0);

        // reset in the middle of a frame
        tick();
        start = 1'b1; mode = 1'b1; base_addr = 10'h080; word_cnt = 10'd3; sym_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
        end
        chk("rstmid_valid_before", sym_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rstmid");
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || busy || ram_rd) bad = 1;
        end
        chk("rstmid_quiet", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
